// File: rtl/spi_seg_pkg.sv
// Shared SPI definitions for the segment master and the segment controller slave.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package spi_seg_pkg;

    // Frame sequencer states of the SPI initiator.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_HIGH,
        ST_LOW,
        ST_GAP
    } spi_state_t;

    // Mode 0: sclk idles low, data sampled on the rising edge.
    localparam bit SPI_CPOL = 1'b0;
    localparam bit SPI_CPHA = 1'b0;

    // Link defaults agreed with the segment controller slave.
    localparam int SPI_CLK_DIV_DEF = 2;
    localparam int SPI_DATA_W_DEF  = 8;

endpackage

// File: rtl/spi_half_tick.sv
// Half-period timer: tick marks the last cycle of every CLK_DIV-cycle SPI phase.
// Latency: tick asserts CLK_DIV-1 cycles after the last clr.
// Backpressure: none; clr restarts the phase count.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clr         restart the phase (asserted on every state change and in idle)
//   tick        high on the final cycle of the current phase
module spi_half_tick #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    logic [7:0] div_cnt;

    assign tick = (div_cnt == 8'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (clr || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/spi_segment_master.sv
// SPI mode-0 initiator: one DATA_W-bit word per handshake becomes one cs_n-framed MSB-first transfer.
// Latency: cs_n falls 1 cycle after accept; tx_ready returns CLK_DIV*(2*DATA_W+2)+1 cycles after accept.
// Backpressure: tx_ready is high only in idle; no queueing, inputs are ignored while a frame runs.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   tx_data/valid/ready word to send and its handshake
//   busy                high whenever a frame (including the trailing gap) is in progress
//   rx_data, rx_valid   word captured from miso and its one-cycle frame-end strobe
//   sclk, cs_n, mosi    SPI outputs; miso SPI input (driven synchronously to clk)
//
// Build option: define SPI_MASTER_MISO_CAPTURE_EN to build the miso capture path.
// Without it rx_data is constant zero and rx_valid is a plain done strobe.
module spi_segment_master
    import spi_seg_pkg::*;
#(
    parameter int CLK_DIV = SPI_CLK_DIV_DEF,
    parameter int DATA_W  = SPI_DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              busy,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              sclk,
    output logic              cs_n,
    output logic              mosi,
    input  logic              miso
);

    localparam int                CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0]  BIT_LAST = CNT_W'(DATA_W - 1);

    spi_state_t        state, state_next;
    logic [DATA_W-1:0] tx_sh;
    logic [CNT_W-1:0]  bit_cnt;
    logic              tick;
    logic              clr;
    logic              entered;   // first cycle of the current state
    logic              last_bit;

    assign last_bit = (bit_cnt == '0);
    assign clr      = (state_next != state) || (state == ST_IDLE);

    spi_half_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_half_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            entered <= 1'b0;
        end else begin
            state   <= state_next;
            entered <= (state_next != state);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (tx_valid) state_next = ST_SETUP;
            ST_SETUP: if (tick)     state_next = ST_HIGH;
            ST_HIGH:  if (tick)     state_next = ST_LOW;
            ST_LOW:   if (tick)     state_next = last_bit ? ST_GAP : ST_HIGH;
            ST_GAP:   if (tick)     state_next = ST_IDLE;
            default:                state_next = ST_IDLE;
        endcase
    end

    // The shift happens as HIGH ends so the next bit is already on mosi
    // during the first LOW cycle; the final bit is held through the last LOW.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_sh   <= '0;
            bit_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (tx_valid) begin
                        tx_sh   <= tx_data;
                        bit_cnt <= BIT_LAST;
                    end
                end
                ST_HIGH: begin
                    if (tick && !last_bit) tx_sh <= tx_sh << 1;
                end
                ST_LOW: begin
                    if (tick && !last_bit) bit_cnt <= bit_cnt - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef SPI_MASTER_MISO_CAPTURE_EN
    logic [DATA_W-1:0] rx_sh;

    // miso is taken once per bit, on the cycle sclk rises. rx_data is loaded
    // as the hold LOW ends so it is already valid during the rx_valid cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sh   <= '0;
            rx_data <= '0;
        end else begin
            if (state == ST_HIGH && entered) begin
                rx_sh <= (rx_sh << 1) | DATA_W'(miso);
            end
            if (state == ST_LOW && tick && last_bit) begin
                rx_data <= rx_sh;
            end
        end
    end
`else
    logic miso_unused;

    assign miso_unused = miso;
    assign rx_data     = '0;
`endif

    always_comb begin
        cs_n     = 1'b1;
        sclk     = SPI_CPOL;
        mosi     = 1'b0;
        tx_ready = (state == ST_IDLE);
        busy     = (state != ST_IDLE);
        rx_valid = (state == ST_GAP) && entered;
        case (state)
            ST_SETUP, ST_LOW: begin
                cs_n = 1'b0;
                mosi = tx_sh[DATA_W-1];
            end
            ST_HIGH: begin
                cs_n = 1'b0;
                sclk = !SPI_CPOL;
                mosi = tx_sh[DATA_W-1];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_spi_segment_master.sv
// Bench for spi_segment_master: default instance plus a CLK_DIV=1, DATA_W=16 instance.
// Latency: expectations per cycle are derived from the frame arithmetic.
// Backpressure: tx_valid holding and mid-frame tx_data changes are exercised.
module tb_spi_segment_master;

    localparam int N0 = 2;
    localparam int W0 = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [7:0]  tx_data, rx_data;
    logic        tx_valid, tx_ready, busy, rx_valid, sclk, cs_n, mosi, miso;

    logic [15:0] d1_tx_data, d1_rx_data;
    logic        d1_tx_valid, d1_tx_ready, d1_busy, d1_rx_valid, d1_sclk, d1_cs_n, d1_mosi, d1_miso;

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  rx_last;

    int          d1_lows, d1_nsclk, d1_vk;
    logic [15:0] d1_bits;

    spi_segment_master dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .busy     (busy),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .sclk     (sclk),
        .cs_n     (cs_n),
        .mosi     (mosi),
        .miso     (miso)
    );

    spi_segment_master #(
        .CLK_DIV (1),
        .DATA_W  (16)
    ) dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_data  (d1_tx_data),
        .tx_valid (d1_tx_valid),
        .tx_ready (d1_tx_ready),
        .busy     (d1_busy),
        .rx_data  (d1_rx_data),
        .rx_valid (d1_rx_valid),
        .sclk     (d1_sclk),
        .cs_n     (d1_cs_n),
        .mosi     (d1_mosi),
        .miso     (d1_miso)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sends one word on the default instance and checks every cycle of the frame.
    // Frame model: phase p = (k-1)/N after accept; p=0 setup, odd p high,
    // even p in 2..2W low, p=2W+1 gap, then idle at k = N*(2W+2)+1.
    task automatic frame(input logic [7:0] word, input bit loopback,
                         input bit hold, input logic [7:0] next_word);
        int         P;
        logic [7:0] rxw;
        logic [7:0] rx_exp;
        P   = N0 * (2 * W0 + 2) + 1;
        rxw = 8'($urandom);
`ifdef SPI_MASTER_MISO_CAPTURE_EN
        rx_exp = loopback ? word : rxw;
`else
        rx_exp = 8'h00;
`endif
        tx_data  = word;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        if (hold) tx_data = next_word;
        else      tx_valid = 1'b0;
        for (int k = 1; k <= P; k++) begin
            int p, ph, b;
            bit in_frame, rise, pulse;
            @(negedge clk);
            p        = (k - 1) / N0;
            ph       = (k - 1) % N0;
            b        = (p - 1) / 2;
            in_frame = (p <= 2 * W0);
            rise     = (p % 2 == 1) && (p <= 2 * W0 - 1) && (ph == 0);
            pulse    = (p == 2 * W0 + 1) && (ph == 0);
            if (pulse) rx_last = rx_exp;
            check("cs_n",     32'(cs_n),     32'(!in_frame));
            check("sclk",     32'(sclk),     32'((p % 2 == 1) && (p <= 2 * W0)));
            check("rx_valid", 32'(rx_valid), 32'(pulse));
            check("rx_data",  32'(rx_data),  32'(rx_last));
            check("tx_ready", 32'(tx_ready), 32'(k == P));
            check("busy",     32'(busy),     32'(k != P));
            if (rise)
                check("mosi_bit", 32'(mosi), 32'(word[W0-1-b]));
            else if (!in_frame)
                check("mosi_idle", 32'(mosi), 32'd0);
            if (rise) miso = loopback ? mosi : rxw[W0-1-b];
            else      miso = 1'($urandom_range(0, 1));
            if (k == P / 2 && !hold) tx_data = ~word;
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        tx_data     = '0;
        tx_valid    = 1'b0;
        miso        = 1'b0;
        d1_tx_data  = '0;
        d1_tx_valid = 1'b0;
        d1_miso     = 1'b0;
        rx_last     = 8'h00;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_cs_n",     32'(cs_n),     32'd1);
        check("rst_sclk",     32'(sclk),     32'd0);
        check("rst_mosi",     32'(mosi),     32'd0);
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_rx_data",  32'(rx_data),  32'd0);
        check("rst_d1_cs_n",  32'(d1_cs_n),  32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed words, loopback, then a batch of random words.
        frame(8'hA5, 1'b0, 1'b0, 8'h00);
        frame(8'h3C, 1'b1, 1'b0, 8'h00);
        frame(8'h00, 1'b0, 1'b0, 8'h00);
        repeat (6) frame(8'($urandom), 1'($urandom_range(0, 1)), 1'b0, 8'h00);

        // Idle with tx_valid low after a frame: nothing new starts.
        repeat (5) begin
            @(negedge clk);
            check("idle_cs_n", 32'(cs_n), 32'd1);
        end

        // Back-to-back with tx_valid held high.
        frame(8'h01, 1'b0, 1'b1, 8'hFF);
        frame(8'hFF, 1'b0, 1'b0, 8'h00);

        // Reset in the middle of a frame (cycle t+15 is a high phase).
        tx_data  = 8'hC3;
        tx_valid = 1'b1;
        @(posedge clk);
        #1 tx_valid = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        check("pre_rst_cs_n", 32'(cs_n), 32'd0);
        check("pre_rst_sclk", 32'(sclk), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_cs_n",     32'(cs_n),     32'd1);
        check("mid_rst_sclk",     32'(sclk),     32'd0);
        check("mid_rst_mosi",     32'(mosi),     32'd0);
        check("mid_rst_busy",     32'(busy),     32'd0);
        check("mid_rst_tx_ready", 32'(tx_ready), 32'd1);
        check("mid_rst_rx_data",  32'(rx_data),  32'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        rx_last = 8'h00;
        @(negedge clk);
        frame(8'h5A, 1'b0, 1'b0, 8'h00);
        frame(8'h96, 1'b1, 1'b0, 8'h00);

        // CLK_DIV=1, DATA_W=16: setup + 32 bit phases with cs_n low, one gap cycle.
        d1_lows    = 0;
        d1_nsclk   = 0;
        d1_vk      = 0;
        d1_bits    = '0;
        d1_tx_data = 16'h8001;
        d1_tx_valid = 1'b1;
        @(posedge clk);
        #1 d1_tx_valid = 1'b0;
        for (int k = 1; k <= 35; k++) begin
            @(negedge clk);
            if (!d1_cs_n) d1_lows++;
            if (d1_sclk) begin
                d1_bits = {d1_bits[14:0], d1_mosi};
                d1_nsclk++;
            end
            if (d1_rx_valid) d1_vk = k;
            if (k == 34) check("d1_ready_gap",  32'(d1_tx_ready), 32'd0);
            if (k == 35) check("d1_ready_idle", 32'(d1_tx_ready), 32'd1);
        end
        check("d1_cs_low_cycles", 32'(d1_lows),    32'd33);
        check("d1_sclk_pulses",   32'(d1_nsclk),   32'd16);
        check("d1_mosi_word",     32'(d1_bits),    32'h8001);
        check("d1_rx_valid_at",   32'(d1_vk),      32'd34);
        check("d1_rx_data",       32'(d1_rx_data), 32'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
